// File: rtl/dcache_axi_bridge_pkg.sv
// Shared definitions for the dcache-to-AXI bridge.
// Contents:
//   - request size encodings used on the cache side (TYPE_B .. TYPE_LINE)
//   - fixed AXI burst/size constants
//   - cache line offset width
//   - FSM state enums for the read and write engines
//   - helper that maps a request type to an AXI size code
package dcache_axi_bridge_pkg;

  localparam logic [2:0] TYPE_B    = 3'd0;
  localparam logic [2:0] TYPE_H    = 3'd1;
  localparam logic [2:0] TYPE_W    = 3'd2;
  localparam logic [2:0] TYPE_D    = 3'd3;
  localparam logic [2:0] TYPE_LINE = 3'd4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'd3;

  localparam int LINE_OFS_W = 4;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;

  // A line moves as two 8-byte beats; uncached accesses use their own size.
  function automatic logic [2:0] axi_size(input logic [2:0] reqType);
    return (reqType == TYPE_LINE) ? SIZE_8B : reqType;
  endfunction

endpackage

// File: rtl/dcache_axi_bridge_axi_write_channel.sv
// Write buffer plus AW/W/B engine for the dcache AXI bridge.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   wr_req_i .. wr_strb_i  cache write request, address, 128-bit data, type, strobe
//   wr_ready_o           buffer empty (forced low during reset)
//   busy_o, line_addr_o  buffer occupied / latched address, used for the RAW check
//   aw*_o/i, w*_o/i, b*_o/i  AXI write address, data and response handshakes
module axi_write_channel #(
  parameter int AXI_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_i,
  input  logic [63:0]           wr_addr_i,
  input  logic [127:0]          wr_data_i,
  input  logic [2:0]            wr_type_i,
  input  logic [7:0]            wr_strb_i,
  output logic                  wr_ready_o,
  output logic                  busy_o,
  output logic [AXI_ADDR_W-1:0] line_addr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [AXI_ADDR_W-1:0] awaddr_o,
  output logic [7:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [63:0]           wdata_o,
  output logic [7:0]            wstrb_o,
  output logic                  wlast_o,
  input  logic                  bvalid_i,
  output logic                  bready_o
);
  import dcache_axi_bridge_pkg::*;

  wr_state_e             wrState_q;
  logic                  awvalid_q, wvalid_q, wlast_q, bready_q;
  logic                  awDone_q, wDone_q;
  logic [AXI_ADDR_W-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic [2:0]            awsize_q;
  logic [63:0]           wdata_q, dataHi_q;
  logic [7:0]            wstrb_q;
  logic                  isLine;
  logic                  awFire, wFire, awDoneNow, wDoneNow;
  logic                  unusedBits;

  assign isLine    = (wr_type_i == TYPE_LINE);
  assign awFire    = awvalid_q && awready_i;
  assign wFire     = wvalid_q && wready_i;
  // Both halves may finish in the same cycle, so include this cycle's handshakes.
  assign awDoneNow = awDone_q || awFire;
  assign wDoneNow  = wDone_q || (wFire && wlast_q);

  // AW and W run independently; wlast_q doubles as the beat index since the
  // high half is only loaded after beat 0 of a line is taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrState_q <= W_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      awDone_q  <= 1'b0;
      wDone_q   <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      dataHi_q  <= '0;
      wstrb_q   <= '0;
    end else begin
      case (wrState_q)
        W_IDLE: begin
          if (wr_req_i && wr_ready_o) begin
            awaddr_q  <= isLine ? {wr_addr_i[AXI_ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}}
                                : wr_addr_i[AXI_ADDR_W-1:0];
            awlen_q   <= isLine ? 8'd1 : 8'd0;
            awsize_q  <= axi_size(wr_type_i);
            wdata_q   <= wr_data_i[63:0];
            dataHi_q  <= wr_data_i[127:64];
            wstrb_q   <= isLine ? 8'hFF : wr_strb_i;
            wlast_q   <= !isLine;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awDone_q  <= 1'b0;
            wDone_q   <= 1'b0;
            wrState_q <= W_REQ;
          end
        end
        W_REQ: begin
          if (awFire) begin
            awvalid_q <= 1'b0;
            awDone_q  <= 1'b1;
          end
          if (wFire) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wDone_q  <= 1'b1;
            end else begin
              wdata_q <= dataHi_q;
              wlast_q <= 1'b1;
            end
          end
          if (awDoneNow && wDoneNow) begin
            bready_q  <= 1'b1;
            wrState_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid_i) begin
            bready_q  <= 1'b0;
            wrState_q <= W_IDLE;
          end
        end
        default: wrState_q <= W_IDLE;
      endcase
    end
  end

  assign wr_ready_o  = rst && (wrState_q == W_IDLE);
  assign busy_o      = (wrState_q != W_IDLE);
  assign line_addr_o = awaddr_q;
  assign awvalid_o   = awvalid_q;
  assign awaddr_o    = awaddr_q;
  assign awlen_o     = awlen_q;
  assign awsize_o    = awsize_q;
  assign wvalid_o    = wvalid_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wlast_o     = wlast_q;
  assign bready_o    = bready_q;

  assign unusedBits = ^wr_addr_i[63:AXI_ADDR_W];

endmodule

// File: rtl/dcache_axi_bridge.sv
// Bridge from the dcache memory-side request interface to an AXI4 master.
// Reads (refill/uncached) become AR/R transactions; writes (write-back/uncached)
// are buffered in axi_write_channel and become AW/W/B transactions.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   axi_rd_* / axi_rdata/rvalid/rlast  cache read request and returned beats
//   axi_wr_* / axi_wdata/axi_wstrb    cache write request, released at acceptance
//   bus_err                         sticky error on any non-OKAY RRESP/BRESP
//   ar*, r*, aw*, w*, b*            AXI4 master channels
module dcache_axi_bridge #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_rd_req,
  input  logic [63:0]           axi_rd_addr,
  input  logic [2:0]            axi_rd_type,
  output logic                  axi_rd_ready,
  output logic [63:0]           axi_rdata,
  output logic                  axi_rvalid,
  output logic                  axi_rlast,
  input  logic                  axi_wr_req,
  input  logic [63:0]           axi_wr_addr,
  input  logic [127:0]          axi_wdata,
  input  logic [2:0]            axi_wr_type,
  input  logic [7:0]            axi_wstrb,
  output logic                  axi_wr_ready,
  output logic                  bus_err,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [3:0]            arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [63:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [3:0]            rid,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_ADDR_W-1:0] awaddr,
  output logic [3:0]            awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [63:0]           wdata,
  output logic [7:0]            wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  input  logic [3:0]            bid
);
  import dcache_axi_bridge_pkg::*;

  rd_state_e             rdState_q;
  logic                  arvalid_q;
  logic [AXI_ADDR_W-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  logic                  busErr_q, busErr_d;
  logic                  wrBusy;
  logic [AXI_ADDR_W-1:0] wrLineAddr;
  logic                  hazard, inData;
  logic                  unusedBits;

  axi_write_channel #(.AXI_ADDR_W(AXI_ADDR_W)) u_write (
    .clk         (clk),
    .rst         (rst),
    .wr_req_i    (axi_wr_req),
    .wr_addr_i   (axi_wr_addr),
    .wr_data_i   (axi_wdata),
    .wr_type_i   (axi_wr_type),
    .wr_strb_i   (axi_wstrb),
    .wr_ready_o  (axi_wr_ready),
    .busy_o      (wrBusy),
    .line_addr_o (wrLineAddr),
    .awvalid_o   (awvalid),
    .awready_i   (awready),
    .awaddr_o    (awaddr),
    .awlen_o     (awlen),
    .awsize_o    (awsize),
    .wvalid_o    (wvalid),
    .wready_i    (wready),
    .wdata_o     (wdata),
    .wstrb_o     (wstrb),
    .wlast_o     (wlast),
    .bvalid_i    (bvalid),
    .bready_o    (bready)
  );

  // A read of a line still sitting in the write buffer must wait for the
  // write response, otherwise it could return stale memory contents.
  assign hazard = wrBusy &&
                  (axi_rd_addr[AXI_ADDR_W-1:LINE_OFS_W] == wrLineAddr[AXI_ADDR_W-1:LINE_OFS_W]);
  assign axi_rd_ready = rst && (rdState_q == R_IDLE) && !hazard;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdState_q <= R_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
    end else begin
      case (rdState_q)
        R_IDLE: begin
          if (axi_rd_req && axi_rd_ready) begin
            araddr_q  <= (axi_rd_type == TYPE_LINE)
                         ? {axi_rd_addr[AXI_ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}}
                         : axi_rd_addr[AXI_ADDR_W-1:0];
            arlen_q   <= (axi_rd_type == TYPE_LINE) ? 8'd1 : 8'd0;
            arsize_q  <= axi_size(axi_rd_type);
            arvalid_q <= 1'b1;
            rdState_q <= R_AR;
          end
        end
        R_AR: begin
          if (arvalid_q && arready) begin
            arvalid_q <= 1'b0;
            rdState_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rlast) rdState_q <= R_IDLE;
        end
        default: rdState_q <= R_IDLE;
      endcase
    end
  end

  // Beats are forwarded straight to the cache; the cache always accepts them.
  assign inData     = (rdState_q == R_DATA);
  assign rready     = inData;
  assign axi_rvalid = inData && rvalid;
  assign axi_rlast  = inData && rlast;
  assign axi_rdata  = inData ? rdata : 64'd0;

  assign busErr_d = busErr_q ||
                    (rvalid && rready && (rresp != 2'b00)) ||
                    (bvalid && bready && (bresp != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst) busErr_q <= 1'b0;
    else      busErr_q <= busErr_d;
  end

  assign bus_err = busErr_q;
  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = BURST_INCR;
  assign arid    = 4'(AXI_ID);
  assign awid    = 4'(AXI_ID);
  assign awburst = BURST_INCR;

  assign unusedBits = ^{axi_rd_addr[63:AXI_ADDR_W], rid, bid, wrLineAddr[LINE_OFS_W-1:0]};

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge. Inputs change 1 time unit after
// the rising edge; a monitor records AXI handshakes and forwarded read beats
// on the falling edge, and each test compares them against its own
// expectation queues.
module tb_dcache_axi_bridge;
  localparam int AW = 32;

  logic clk, rst;
  logic axi_rd_req;  logic [63:0] axi_rd_addr; logic [2:0] axi_rd_type;
  logic axi_rd_ready; logic [63:0] axi_rdata; logic axi_rvalid, axi_rlast;
  logic axi_wr_req;  logic [63:0] axi_wr_addr; logic [127:0] axi_wdata;
  logic [2:0] axi_wr_type; logic [7:0] axi_wstrb; logic axi_wr_ready;
  logic bus_err;
  logic arvalid, arready; logic [AW-1:0] araddr; logic [3:0] arid;
  logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
  logic rvalid, rready; logic [63:0] rdata; logic [1:0] rresp; logic rlast; logic [3:0] rid;
  logic awvalid, awready; logic [AW-1:0] awaddr; logic [3:0] awid;
  logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst;
  logic wvalid, wready; logic [63:0] wdata; logic [7:0] wstrb; logic wlast;
  logic bvalid, bready; logic [1:0] bresp; logic [3:0] bid;

  int assertCount = 0;
  int failCount   = 0;

  // {rlast, rdata}, {wlast, wstrb, wdata}, {addr, len, size}
  logic [64:0] rdExpQ[$], rdObsQ[$];
  logic [72:0] wExpQ[$],  wObsQ[$];
  logic [42:0] arExpQ[$], arObsQ[$];
  logic [42:0] awExpQ[$], awObsQ[$];

  dcache_axi_bridge #(.AXI_ADDR_W(AW), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst),
    .axi_rd_req(axi_rd_req), .axi_rd_addr(axi_rd_addr), .axi_rd_type(axi_rd_type),
    .axi_rd_ready(axi_rd_ready), .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
    .axi_rlast(axi_rlast),
    .axi_wr_req(axi_wr_req), .axi_wr_addr(axi_wr_addr), .axi_wdata(axi_wdata),
    .axi_wr_type(axi_wr_type), .axi_wstrb(axi_wstrb), .axi_wr_ready(axi_wr_ready),
    .bus_err(bus_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (axi_rvalid)          rdObsQ.push_back({axi_rlast, axi_rdata});
    if (wvalid && wready)    wObsQ.push_back({wlast, wstrb, wdata});
    if (arvalid && arready)  arObsQ.push_back({araddr, arlen, arsize});
    if (awvalid && awready)  awObsQ.push_back({awaddr, awlen, awsize});
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    axi_rd_req = 0; axi_rd_addr = '0; axi_rd_type = '0;
    axi_wr_req = 0; axi_wr_addr = '0; axi_wdata = '0; axi_wr_type = '0; axi_wstrb = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    repeat (3) cyc();
    assertCount++;
    if ({arvalid, awvalid, wvalid, rready, bready, axi_rvalid, axi_rlast, bus_err,
         axi_rd_ready, axi_wr_ready} !== 10'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000000000",
               {arvalid, awvalid, wvalid, rready, bready, axi_rvalid, axi_rlast, bus_err,
                axi_rd_ready, axi_wr_ready});
    end
    rst = 1'b1;
    cyc();
    assertCount++;
    if ({axi_rd_ready, axi_wr_ready} !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL reset_release_ready: got %b expected 11", {axi_rd_ready, axi_wr_ready});
    end
  endtask

  task automatic test_line_refill();
    logic [64:0] expR, obsR;
    logic [42:0] expA, obsA;
    axi_rd_req = 1; axi_rd_addr = 64'h0000_0000_8000_1238; axi_rd_type = 3'd4;
    #1;
    assertCount++;
    if (axi_rd_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL refill_accept_ready: got %b expected 1", axi_rd_ready);
    end
    cyc();
    axi_rd_req = 0;
    arExpQ.push_back({32'h8000_1230, 8'd1, 3'd3});
    for (int i = 0; i < 3; i++) begin
      #1;
      assertCount++;
      if ({arvalid, araddr, arlen, arsize, arburst} !== {1'b1, 32'h8000_1230, 8'd1, 3'd3, 2'b01}) begin
        failCount++;
        $display("[TB] FAIL refill_ar_stall%0d: got v=%b a=%h l=%0d s=%0d b=%b expected v=1 a=80001230 l=1 s=3 b=01",
                 i, arvalid, araddr, arlen, arsize, arburst);
      end
      cyc();
    end
    arready = 1;
    cyc();
    arready = 0;
    #1;
    assertCount++;
    if ({arvalid, rready} !== 2'b01) begin
      failCount++; $display("[TB] FAIL refill_rdata_state: got arvalid,rready=%b expected 01", {arvalid, rready});
    end
    rdExpQ.push_back({1'b0, 64'h1111_1111_1111_1111});
    rdExpQ.push_back({1'b1, 64'h2222_2222_2222_2222});
    rvalid = 1; rdata = 64'h1111_1111_1111_1111; rlast = 0;
    cyc();
    rdata = 64'h2222_2222_2222_2222; rlast = 1;
    cyc();
    rvalid = 0; rlast = 0; rdata = '0;
    #1;
    assertCount++;
    if (axi_rd_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL refill_ready_after: got %b expected 1", axi_rd_ready);
    end
    while (rdExpQ.size() > 0) begin
      expR = rdExpQ.pop_front();
      assertCount++;
      if (rdObsQ.size() == 0) begin
        failCount++; $display("[TB] FAIL refill_rbeat: got none expected %h", expR);
      end else begin
        obsR = rdObsQ.pop_front();
        if (obsR !== expR) begin
          failCount++; $display("[TB] FAIL refill_rbeat: got %h expected %h", obsR, expR);
        end
      end
    end
    expA = arExpQ.pop_front();
    assertCount++;
    if (arObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL refill_ar_hs: got none expected %h", expA);
    end else begin
      obsA = arObsQ.pop_front();
      if (obsA !== expA) begin
        failCount++; $display("[TB] FAIL refill_ar_hs: got %h expected %h", obsA, expA);
      end
    end
  endtask

  task automatic test_uncached_read();
    logic [64:0] expR, obsR;
    logic [42:0] expA, obsA;
    axi_rd_req = 1; axi_rd_addr = 64'h0000_0000_1000_0004; axi_rd_type = 3'd2;
    cyc();
    axi_rd_req = 0;
    arExpQ.push_back({32'h1000_0004, 8'd0, 3'd2});
    arready = 1;
    cyc();
    arready = 0;
    rdExpQ.push_back({1'b1, 64'hCAFE_F00D_1234_5678});
    rvalid = 1; rdata = 64'hCAFE_F00D_1234_5678; rlast = 1;
    cyc();
    rvalid = 0; rlast = 0; rdata = '0;
    #1;
    assertCount++;
    if (axi_rd_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL ucread_ready_after: got %b expected 1", axi_rd_ready);
    end
    expR = rdExpQ.pop_front();
    assertCount++;
    if (rdObsQ.size() != 1) begin
      failCount++; $display("[TB] FAIL ucread_beats: got %0d beats expected 1", rdObsQ.size());
      rdObsQ.delete();
    end else begin
      obsR = rdObsQ.pop_front();
      if (obsR !== expR) begin
        failCount++; $display("[TB] FAIL ucread_rbeat: got %h expected %h", obsR, expR);
      end
    end
    expA = arExpQ.pop_front();
    assertCount++;
    if (arObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL ucread_ar_hs: got none expected %h", expA);
    end else begin
      obsA = arObsQ.pop_front();
      if (obsA !== expA) begin
        failCount++; $display("[TB] FAIL ucread_ar_hs: got %h expected %h", obsA, expA);
      end
    end
  endtask

  task automatic test_writeback();
    logic [72:0] expW, obsW;
    logic [42:0] expA, obsA;
    axi_wr_req = 1; axi_wr_addr = 64'h0000_0000_8000_0040; axi_wr_type = 3'd4;
    axi_wdata = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB}; axi_wstrb = 8'h00;
    #1;
    assertCount++;
    if (axi_wr_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL wb_accept_ready: got %b expected 1", axi_wr_ready);
    end
    cyc();
    axi_wr_req = 0;
    wExpQ.push_back({1'b0, 8'hFF, 64'hBBBB_BBBB_BBBB_BBBB});
    wExpQ.push_back({1'b1, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA});
    awExpQ.push_back({32'h8000_0040, 8'd1, 3'd3});
    wready = 1;
    repeat (2) begin
      #1;
      assertCount++;
      if (axi_wr_ready !== 1'b0) begin
        failCount++; $display("[TB] FAIL wb_busy: got %b expected 0", axi_wr_ready);
      end
      cyc();
    end
    wready = 0; awready = 1;
    #1;
    assertCount++;
    if ({awvalid, wvalid, axi_wr_ready} !== 3'b100) begin
      failCount++; $display("[TB] FAIL wb_aw_pending: got awvalid,wvalid,wr_ready=%b expected 100",
                            {awvalid, wvalid, axi_wr_ready});
    end
    cyc();
    awready = 0;
    #1;
    assertCount++;
    if ({bready, awvalid, axi_wr_ready} !== 3'b100) begin
      failCount++; $display("[TB] FAIL wb_resp_state: got bready,awvalid,wr_ready=%b expected 100",
                            {bready, awvalid, axi_wr_ready});
    end
    bvalid = 1; bresp = 2'b00;
    cyc();
    bvalid = 0;
    #1;
    assertCount++;
    if (axi_wr_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL wb_ready_after_b: got %b expected 1", axi_wr_ready);
    end
    while (wExpQ.size() > 0) begin
      expW = wExpQ.pop_front();
      assertCount++;
      if (wObsQ.size() == 0) begin
        failCount++; $display("[TB] FAIL wb_wbeat: got none expected %h", expW);
      end else begin
        obsW = wObsQ.pop_front();
        if (obsW !== expW) begin
          failCount++; $display("[TB] FAIL wb_wbeat: got %h expected %h", obsW, expW);
        end
      end
    end
    expA = awExpQ.pop_front();
    assertCount++;
    if (awObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL wb_aw_hs: got none expected %h", expA);
    end else begin
      obsA = awObsQ.pop_front();
      if (obsA !== expA) begin
        failCount++; $display("[TB] FAIL wb_aw_hs: got %h expected %h", obsA, expA);
      end
    end
  endtask

  task automatic test_uncached_write();
    logic [72:0] expW, obsW;
    logic [42:0] expA, obsA;
    axi_wr_req = 1; axi_wr_addr = 64'h0000_0000_1000_0004; axi_wr_type = 3'd0;
    axi_wdata = {64'hDEAD_DEAD_DEAD_DEAD, 64'h0000_00AB_0000_0000}; axi_wstrb = 8'h10;
    cyc();
    axi_wr_req = 0;
    wExpQ.push_back({1'b1, 8'h10, 64'h0000_00AB_0000_0000});
    awExpQ.push_back({32'h1000_0004, 8'd0, 3'd0});
    awready = 1; wready = 1;
    cyc();
    awready = 0; wready = 0;
    bvalid = 1; bresp = 2'b00;
    cyc();
    bvalid = 0;
    #1;
    assertCount++;
    if ({axi_wr_ready, bus_err} !== 2'b10) begin
      failCount++; $display("[TB] FAIL ucwr_done: got wr_ready,bus_err=%b expected 10", {axi_wr_ready, bus_err});
    end
    expW = wExpQ.pop_front();
    assertCount++;
    if (wObsQ.size() != 1) begin
      failCount++; $display("[TB] FAIL ucwr_beats: got %0d beats expected 1", wObsQ.size());
      wObsQ.delete();
    end else begin
      obsW = wObsQ.pop_front();
      if (obsW !== expW) begin
        failCount++; $display("[TB] FAIL ucwr_wbeat: got %h expected %h", obsW, expW);
      end
    end
    expA = awExpQ.pop_front();
    assertCount++;
    if (awObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL ucwr_aw_hs: got none expected %h", expA);
    end else begin
      obsA = awObsQ.pop_front();
      if (obsA !== expA) begin
        failCount++; $display("[TB] FAIL ucwr_aw_hs: got %h expected %h", obsA, expA);
      end
    end
  endtask

  task automatic test_raw_hazard();
    logic [64:0] expR, obsR;
    logic [72:0] expW, obsW;
    logic [42:0] expA, obsA;
    axi_wr_req = 1; axi_wr_addr = 64'h0000_0000_8000_0040; axi_wr_type = 3'd4;
    axi_wdata = {64'hCCCC_0000_CCCC_0000, 64'hDDDD_0000_DDDD_0000}; axi_wstrb = 8'h00;
    cyc();
    axi_wr_req = 0;
    wExpQ.push_back({1'b0, 8'hFF, 64'hDDDD_0000_DDDD_0000});
    wExpQ.push_back({1'b1, 8'hFF, 64'hCCCC_0000_CCCC_0000});
    awExpQ.push_back({32'h8000_0040, 8'd1, 3'd3});
    axi_rd_req = 1; axi_rd_addr = 64'h0000_0000_8000_0048; axi_rd_type = 3'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      assertCount++;
      if (axi_rd_ready !== 1'b0) begin
        failCount++; $display("[TB] FAIL raw_same_line_held%0d: got %b expected 0", i, axi_rd_ready);
      end
      cyc();
    end
    axi_rd_addr = 64'h0000_0000_8000_0080;
    #1;
    assertCount++;
    if (axi_rd_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL raw_other_line_ready: got %b expected 1", axi_rd_ready);
    end
    cyc();
    axi_rd_req = 0;
    arExpQ.push_back({32'h8000_0080, 8'd0, 3'd3});
    arready = 1;
    cyc();
    arready = 0;
    rdExpQ.push_back({1'b1, 64'hEEEE_1234_EEEE_5678});
    rvalid = 1; rdata = 64'hEEEE_1234_EEEE_5678; rlast = 1;
    cyc();
    rvalid = 0; rlast = 0; rdata = '0;
    axi_rd_req = 1; axi_rd_addr = 64'h0000_0000_8000_0048;
    awready = 1; wready = 1;
    cyc();
    awready = 0;
    cyc();
    wready = 0;
    #1;
    assertCount++;
    if (axi_rd_ready !== 1'b0) begin
      failCount++; $display("[TB] FAIL raw_held_in_resp: got %b expected 0", axi_rd_ready);
    end
    bvalid = 1; bresp = 2'b00;
    #1;
    assertCount++;
    if (axi_rd_ready !== 1'b0) begin
      failCount++; $display("[TB] FAIL raw_held_at_bvalid: got %b expected 0", axi_rd_ready);
    end
    cyc();
    bvalid = 0; axi_rd_req = 0;
    #1;
    assertCount++;
    if (axi_rd_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL raw_release: got %b expected 1", axi_rd_ready);
    end
    expR = rdExpQ.pop_front();
    assertCount++;
    if (rdObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL raw_rbeat: got none expected %h", expR);
    end else begin
      obsR = rdObsQ.pop_front();
      if (obsR !== expR) begin
        failCount++; $display("[TB] FAIL raw_rbeat: got %h expected %h", obsR, expR);
      end
    end
    expA = arExpQ.pop_front();
    assertCount++;
    if (arObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL raw_ar_hs: got none expected %h", expA);
    end else begin
      obsA = arObsQ.pop_front();
      if (obsA !== expA) begin
        failCount++; $display("[TB] FAIL raw_ar_hs: got %h expected %h", obsA, expA);
      end
    end
    expA = awExpQ.pop_front();
    assertCount++;
    if (awObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL raw_aw_hs: got none expected %h", expA);
    end else begin
      obsA = awObsQ.pop_front();
      if (obsA !== expA) begin
        failCount++; $display("[TB] FAIL raw_aw_hs: got %h expected %h", obsA, expA);
      end
    end
    while (wExpQ.size() > 0) begin
      expW = wExpQ.pop_front();
      assertCount++;
      if (wObsQ.size() == 0) begin
        failCount++; $display("[TB] FAIL raw_wbeat: got none expected %h", expW);
      end else begin
        obsW = wObsQ.pop_front();
        if (obsW !== expW) begin
          failCount++; $display("[TB] FAIL raw_wbeat: got %h expected %h", obsW, expW);
        end
      end
    end
  endtask

  task automatic test_error_reset();
    logic [64:0] expR, obsR;
    logic [72:0] expW, obsW;
    logic [42:0] expA, obsA;
    axi_wr_req = 1; axi_wr_addr = 64'h0000_0000_1000_0010; axi_wr_type = 3'd3;
    axi_wdata = {64'h0, 64'h0123_4567_89AB_CDEF}; axi_wstrb = 8'hFF;
    cyc();
    axi_wr_req = 0;
    wExpQ.push_back({1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF});
    awExpQ.push_back({32'h1000_0010, 8'd0, 3'd3});
    awready = 1; wready = 1;
    cyc();
    awready = 0; wready = 0;
    bvalid = 1; bresp = 2'b10;
    cyc();
    bvalid = 0; bresp = 2'b00;
    #1;
    assertCount++;
    if (bus_err !== 1'b1) begin
      failCount++; $display("[TB] FAIL err_set: got %b expected 1", bus_err);
    end
    repeat (3) cyc();
    assertCount++;
    if (bus_err !== 1'b1) begin
      failCount++; $display("[TB] FAIL err_sticky: got %b expected 1", bus_err);
    end
    axi_rd_req = 1; axi_rd_addr = 64'h0000_0000_2000_0000; axi_rd_type = 3'd3;
    cyc();
    axi_rd_req = 0;
    arExpQ.push_back({32'h2000_0000, 8'd0, 3'd3});
    arready = 1;
    cyc();
    arready = 0;
    #1;
    assertCount++;
    if (rready !== 1'b1) begin
      failCount++; $display("[TB] FAIL err_in_rdata: got rready=%b expected 1", rready);
    end
    // This beat is visible for the cycle before the reset edge takes effect.
    rdExpQ.push_back({1'b0, 64'h5555_6666_7777_8888});
    rst = 0; rvalid = 1; rdata = 64'h5555_6666_7777_8888; rlast = 0;
    cyc();
    assertCount++;
    if ({arvalid, awvalid, wvalid, rready, bready, axi_rvalid, axi_rlast, bus_err,
         axi_rd_ready, axi_wr_ready} !== 10'b0) begin
      failCount++;
      $display("[TB] FAIL err_reset_clears: got %b expected 0000000000",
               {arvalid, awvalid, wvalid, rready, bready, axi_rvalid, axi_rlast, bus_err,
                axi_rd_ready, axi_wr_ready});
    end
    rvalid = 0; rdata = '0;
    rst = 1;
    cyc();
    assertCount++;
    if ({axi_rd_ready, axi_wr_ready, bus_err} !== 3'b110) begin
      failCount++; $display("[TB] FAIL err_after_reset: got %b expected 110", {axi_rd_ready, axi_wr_ready, bus_err});
    end
    expW = wExpQ.pop_front();
    assertCount++;
    if (wObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL err_wbeat: got none expected %h", expW);
    end else begin
      obsW = wObsQ.pop_front();
      if (obsW !== expW) begin
        failCount++; $display("[TB] FAIL err_wbeat: got %h expected %h", obsW, expW);
      end
    end
    expA = awExpQ.pop_front();
    assertCount++;
    if (awObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL err_aw_hs: got none expected %h", expA);
    end else begin
      obsA = awObsQ.pop_front();
      if (obsA !== expA) begin
        failCount++; $display("[TB] FAIL err_aw_hs: got %h expected %h", obsA, expA);
      end
    end
    expA = arExpQ.pop_front();
    assertCount++;
    if (arObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL err_ar_hs: got none expected %h", expA);
    end else begin
      obsA = arObsQ.pop_front();
      if (obsA !== expA) begin
        failCount++; $display("[TB] FAIL err_ar_hs: got %h expected %h", obsA, expA);
      end
    end
    expR = rdExpQ.pop_front();
    assertCount++;
    if (rdObsQ.size() == 0) begin
      failCount++; $display("[TB] FAIL err_rbeat: got none expected %h", expR);
    end else begin
      obsR = rdObsQ.pop_front();
      if (obsR !== expR) begin
        failCount++; $display("[TB] FAIL err_rbeat: got %h expected %h", obsR, expR);
      end
    end
  endtask

  task automatic test_no_stray_traffic();
    assertCount++;
    if ((rdObsQ.size() + wObsQ.size() + arObsQ.size() + awObsQ.size()) != 0) begin
      failCount++;
      $display("[TB] FAIL stray_handshakes: got r=%0d w=%0d ar=%0d aw=%0d expected all 0",
               rdObsQ.size(), wObsQ.size(), arObsQ.size(), awObsQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_line_refill();
    test_uncached_read();
    test_writeback();
    test_uncached_write();
    test_raw_hazard();
    test_error_reset();
    repeat (2) cyc();
    test_no_stray_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dcache_axi_bridge.md
Name: dcache_axi_bridge

Overview:
Responder to the dcache's memory-side request interface. It accepts line refills, uncached reads, line write-backs and uncached writes, and converts them into AXI4 master transactions: AR/R for reads, AW/W/B for writes. Writes are buffered, so the cache is released at acceptance. The bridge sits between decache and the SoC AXI crossbar.

Parameters:
AXI_ADDR_W, 32, AXI address width; araddr/awaddr take the low AXI_ADDR_W bits of the 64-bit cache address.
AXI_ID, 0, constant arid/awid value.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low (asserted when 0)
axi_rd_req  input  1  cache read request
axi_rd_addr  input  64  read address
axi_rd_type  input  3  0:1B 1:2B 2:4B 3:8B 4:16B cache line
axi_rd_ready  output  1  read engine can accept; accept = req&&ready
axi_rdata  output  64  read beat data
axi_rvalid  output  1  read beat valid
axi_rlast  output  1  final beat of the read
axi_wr_req  input  1  cache write request
axi_wr_addr  input  64  write address
axi_wdata  input  128  line data, or uncached data in [63:0]
axi_wr_type  input  3  same encoding as rd_type
axi_wstrb  input  8  byte strobe, uncached writes only
axi_wr_ready  output  1  write buffer empty; accept = req&&ready
bus_err  output  1  sticky; set on any RRESP/BRESP != 0
arvalid, arready, araddr[AXI_ADDR_W], arid[4], arlen[8], arsize[3], arburst[2]  AXI AR channel (arready is input)
rvalid, rready, rdata[64], rresp[2], rlast, rid[4]  AXI R channel (rready is output)
awvalid, awready, awaddr, awid, awlen, awsize, awburst  AXI AW channel (awready is input)
wvalid, wready, wdata[64], wstrb[8], wlast  AXI W channel (wready is input)
bvalid, bready, bresp[2], bid[4]  AXI B channel (bready is output)

Behaviour:
- Reset (rst==0 at a clk edge): both FSMs go idle. arvalid, awvalid, wvalid, rready, bready, axi_rvalid, axi_rlast and bus_err are 0. axi_rd_ready and axi_wr_ready are forced to 0 while rst==0. Reset mid-transaction abandons the transaction; this is legal only under a system-wide reset.
- Read FSM states are R_IDLE, R_AR and R_DATA.
  - axi_rd_ready = (R_IDLE) && !hazard.
  - On acceptance, latch addr/type and go to R_AR. arvalid is registered and is 1 from the next cycle.
  - type 4: arlen=1, arsize=3, arburst=INCR, araddr = addr & ~0xF.
  - type 0-3: arlen=0, arsize=type, araddr = addr unmodified.
  - R_AR leaves on arvalid&&arready, drops arvalid and goes to R_DATA.
- R_DATA:
  - rready=1.
  - axi_rdata, axi_rvalid and axi_rlast are rvalid, rdata and rlast passed through combinationally, gated by R_DATA.
  - Leaves on rvalid&&rlast and returns to R_IDLE; a new read is acceptable in the following cycle.
  - Beat order is low 64 bits first.
- Write FSM states are W_IDLE, W_REQ and W_RESP.
  - axi_wr_ready = W_IDLE.
  - On acceptance, latch addr, type, the 128-bit data and wstrb.
  - type 4: awlen=1, awsize=3, awaddr line-aligned. Beat 0 is wdata[63:0] and beat 1 is wdata[127:64], both with wstrb=8'hFF; wlast is on beat 1.
  - type 0-3: awlen=0, awsize=type, a single beat with the latched wstrb and wlast=1.
  - W_REQ asserts awvalid and wvalid together from the cycle after acceptance. The AW and W handshakes complete independently and in either order; aw_done and the beat counter track them, and each valid drops after its own handshake.
  - When aw_done && last beat accepted, go to W_RESP with bready=1. On bvalid, return to W_IDLE.
- Valid stability: arvalid, awvalid and wvalid, once high, hold along with their payloads until the handshake. They never depend combinationally on ready.
- RAW hazard: hazard = (W_REQ or W_RESP) && rd_addr[AXI_ADDR_W-1:4] == latched wr_addr[AXI_ADDR_W-1:4]. While hazard holds, the read is held off until B completes. A different line proceeds in parallel.
- The dcache waits on axi_wr_ready even for a clean miss. axi_wr_ready therefore depends only on the buffer being empty, never on axi_wr_req.
- A simultaneous rd_req and wr_req at the same cycle are both accepted; the hazard is evaluated against the previously latched write only.
- bus_err is set on an rvalid with rresp!=0 or a bvalid with bresp!=0, and cleared only by reset. Data is still delivered.
- Unused IDs are tied to AXI_ID. rid/bid are not checked.

Decomposition:
- Shared package holds:
  - the request type encodings (TYPE_B=0 ... TYPE_LINE=4);
  - AXI constants: BURST_INCR=2'b01, SIZE_8B=3'd3;
  - the line-offset width of 4.
- One sub-module, axi_write_channel: the write buffer plus the AW/W/B FSM. It exports busy and the latched line address to the top, which uses them for hazard logic.

Test Plan:
- Line refill at addr 0x8000_1238, type 4, arready held 0 for 3 cycles:
  - araddr=0x8000_1230, arlen=1, arsize=3, and arvalid stable across the stall;
  - two beats 0x11.., 0x22.. forwarded, axi_rlast only on beat 2;
  - rd_ready returns the cycle after.
- Uncached 4B read at 0x1000_0004: arlen=0, arsize=2, a single beat with axi_rlast=1.
- Write-back at 0x8000_0040 with data {A,B}:
  - awready arrives 2 cycles after wready: W beats B then A with wstrb FF, wlast on the second beat;
  - axi_wr_ready is 0 until bvalid, then 1.
- Uncached 1B write, wstrb=8'h10 at 0x1000_0004: awlen=0, awsize=0, a single beat with wstrb 8'h10 and wlast=1.
- RAW hazard: write-back to line 0x8000_0040 is pending; a read of 0x8000_0048 keeps rd_ready=0 until bvalid; a read of 0x8000_0080 is accepted immediately.
- Error and reset:
  - bresp=2'b10 sets bus_err and it stays 1;
  - rst=0 during R_DATA clears all valids and bus_err at the next edge.
